// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: MSB-first payload, optional parity, idle gap.
// Define SERIAL_PATTERN_TX_PARITY_EN to append an even-parity bit.
module serial_pattern_tx #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_W-1:0]       tx_data,
  input  logic [$clog2(DATA_W):0] tx_len,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic                    ser_out,
  output logic                    ser_active,
  output logic                    done
);

  localparam int LW = $clog2(DATA_W) + 1;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE, S_SHIFT, S_PARITY, S_GAP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_SHIFT, S_GAP
  } state_t;
`endif

  state_t            r_state;
  state_t            w_next;
  state_t            w_tail;
  logic [DATA_W-1:0] r_shift;
  logic [LW-1:0]     r_cnt;
  logic [3:0]        r_gap;
  logic              r_done;
  logic [LW-1:0]     w_len;
  logic [LW-1:0]     w_sh;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  logic              r_par;
`endif

  // Out-of-range or zero length means a full-width frame.
  always_comb begin
    w_len = tx_len;
    if (tx_len == '0 || tx_len > LW'(DATA_W))
      w_len = LW'(DATA_W);
    w_sh = LW'(DATA_W) - w_len;
  end

  always_comb begin
    w_tail = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (tx_valid) w_next = S_SHIFT;
      S_SHIFT:
        if (r_cnt == LW'(1)) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          w_next = S_PARITY;
`else
          w_next = w_tail;
`endif
        end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      S_PARITY:
        w_next = w_tail;
`endif
      S_GAP:
        if (r_gap <= 4'd1) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Payload is left-aligned so the next bit is always the MSB.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_done  <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE:
          if (tx_valid) begin
            r_shift <= tx_data << w_sh;
            r_cnt   <= w_len;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
          end
        S_SHIFT: begin
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt - LW'(1);
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          r_par   <= r_par ^ r_shift[DATA_W-1];
`endif
          if (r_cnt == LW'(1)) begin
            r_gap <= 4'(GAP_CYCLES);
`ifndef SERIAL_PATTERN_TX_PARITY_EN
            r_done <= 1'b1;
`endif
          end
        end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        S_PARITY: begin
          r_done <= 1'b1;
          r_gap  <= 4'(GAP_CYCLES);
        end
`endif
        S_GAP:
          r_gap <= r_gap - 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    ser_out = 1'b0;
    case (r_state)
      S_SHIFT:  ser_out = r_shift[DATA_W-1];
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      S_PARITY: ser_out = r_par;
`endif
      default:  ser_out = 1'b0;
    endcase
  end

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  assign ser_active = (r_state == S_SHIFT) || (r_state == S_PARITY);
`else
  assign ser_active = (r_state == S_SHIFT);
`endif
  assign tx_ready = (r_state == S_IDLE);
  assign done     = r_done;

endmodule
